// File: rtl/wt_mac_accumulator_pkg.sv
// wt_mac_accumulator_pkg: shared widths and FSM state encoding for the MAC stage
package wt_mac_accumulator_pkg;
  localparam int OP_W = 4;
  localparam int PROD_W = 8;
  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/wt_mac_accumulator_if.sv
// wt_mac_accumulator_if: operand-in and result-out handshakes of the MAC stage
interface wt_mac_accumulator_if
  import wt_mac_accumulator_pkg::*;
#(
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  A;
  logic [OP_W-1:0]  B;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] Sum;
  logic             ovf;
  modport master(output in_valid, A, B, out_ready, input in_ready, out_valid, Sum, ovf);
  modport slave(input in_valid, A, B, out_ready, output in_ready, out_valid, Sum, ovf);
endinterface

// File: rtl/WallaceTree_Mul.sv
// WallaceTree_Mul: 4x4 unsigned multiplier, partial products reduced by two 3:2 carry-save layers
module WallaceTree_Mul
  import wt_mac_accumulator_pkg::*;
(
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic [PROD_W-1:0] Result
);
  logic [PROD_W-1:0] w_pp [OP_W];
  logic [PROD_W-1:0] w_s1, w_c1, w_s2, w_c2;
  // shifted partial products, then 4 -> 3 -> 2 rows and a final carry-propagate add
  always_comb begin
    for (int i = 0; i < OP_W; i++) w_pp[i] = B[i] ? PROD_W'(A) << i : '0;
    w_s1 = w_pp[0] ^ w_pp[1] ^ w_pp[2];
    w_c1 = ((w_pp[0] & w_pp[1]) | (w_pp[0] & w_pp[2]) | (w_pp[1] & w_pp[2])) << 1;
    w_s2 = w_s1 ^ w_c1 ^ w_pp[3];
    w_c2 = ((w_s1 & w_c1) | (w_s1 & w_pp[3]) | (w_c1 & w_pp[3])) << 1;
    Result = w_s2 + w_c2;
  end
endmodule

// File: rtl/wt_mac_accumulator.sv
// wt_mac_accumulator: sums N_TERMS registered 4x4 products and hands the result out on a valid/ready port
module wt_mac_accumulator
  import wt_mac_accumulator_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 16
) (
  input logic clk,
  input logic rst,
  input logic clr,
  wt_mac_accumulator_if.slave bus
);
  localparam int CNT_W = $clog2(N_TERMS + 1);
  state_t            r_state, w_next;
  logic [OP_W-1:0]   r_op_a, r_op_b;
  logic              r_s1_valid;
  logic [CNT_W-1:0]  r_term_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic              r_ovf;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W:0]    w_sum;
  logic              w_accept, w_consume;
  // clr wins over both handshakes in the same cycle
  assign w_accept  = bus.in_valid && r_state == ST_ACC && !clr;
  assign w_consume = bus.out_ready && r_state == ST_DONE;
  assign w_sum     = {1'b0, r_acc} + (ACC_W + 1)'(w_prod);
  WallaceTree_Mul u_mul (
    .A      (r_op_a),
    .B      (r_op_b),
    .Result (w_prod)
  );
  // state register, frame abort returns to ACC
  always_ff @(posedge clk) r_state <= (rst || clr) ? ST_ACC : w_next;
  // last accepted term drains one cycle, then the result waits for the consumer
  always_comb begin
    w_next = r_state == ST_ACC   ? ((w_accept && r_term_cnt == CNT_W'(N_TERMS - 1)) ? ST_DRAIN : ST_ACC) :
             r_state == ST_DRAIN ? ST_DONE :
             bus.out_ready       ? ST_ACC : ST_DONE;
  end
  // handshake outputs decode from state only, Sum always shows the running total
  always_comb begin
    bus.in_ready  = r_state == ST_ACC;
    bus.out_valid = r_state == ST_DONE;
    bus.Sum       = r_acc;
    bus.ovf       = r_ovf;
  end
  // operand capture, term count and accumulation with sticky wrap flag
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_s1_valid <= 1'b0;
      r_term_cnt <= '0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_op_a <= bus.A;
        r_op_b <= bus.B;
      end
      r_term_cnt <= w_consume ? '0 : w_accept ? r_term_cnt + 1'b1 : r_term_cnt;
      r_acc      <= w_consume ? '0 : r_s1_valid ? w_sum[ACC_W-1:0] : r_acc;
      r_ovf      <= w_consume ? 1'b0 : r_ovf | (r_s1_valid & w_sum[ACC_W]);
    end
  end
endmodule

// File: tb/tb_wt_mac_accumulator.sv
// tb_wt_mac_accumulator: directed frames on a 4-term/16-bit and a 2-term/8-bit instance, scoreboard on the result port
module tb_wt_mac_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr4 = 1'b0;
  logic clr2 = 1'b0;
  int n_checks = 0;
  int n_err = 0;
  logic [16:0] q4[$];
  logic [8:0]  q2[$];
  logic [16:0] e4;
  logic [8:0]  e2;
  logic [3:0]  av[4];
  logic [3:0]  bv[4];
  wt_mac_accumulator_if #(.ACC_W(16)) if4 ();
  wt_mac_accumulator_if #(.ACC_W(8))  if2 ();
  wt_mac_accumulator #(.N_TERMS(4), .ACC_W(16)) u4 (.clk(clk), .rst(rst), .clr(clr4), .bus(if4.slave));
  wt_mac_accumulator #(.N_TERMS(2), .ACC_W(8))  u2 (.clk(clk), .rst(rst), .clr(clr2), .bus(if2.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic put(input bit s, input logic [3:0] a, input logic [3:0] b);
    int t = 0;
    if (s) begin
      if2.A = a; if2.B = b; if2.in_valid = 1'b1;
    end else begin
      if4.A = a; if4.B = b; if4.in_valid = 1'b1;
    end
    while (!(s ? if2.in_ready : if4.in_ready) && t < 50) begin
      step();
      t++;
    end
    chk("in_ready_wait", int'(t < 50), 1);
    step();
    if (s) if2.in_valid = 1'b0;
    else if4.in_valid = 1'b0;
  endtask
  task automatic frame(input bit s, input int n, input int gap, input int exp_sum, input bit exp_ovf);
    if (s) q2.push_back({exp_ovf, 8'(exp_sum)});
    else q4.push_back({exp_ovf, 16'(exp_sum)});
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap)) step();
      put(s, av[i], bv[i]);
    end
    chk("drain_in_ready", int'(s ? if2.in_ready : if4.in_ready), 0);
    chk("drain_out_valid", int'(s ? if2.out_valid : if4.out_valid), 0);
    step();
    chk("done_out_valid", int'(s ? if2.out_valid : if4.out_valid), 1);
    chk("done_in_ready", int'(s ? if2.in_ready : if4.in_ready), 0);
    chk("done_sum", int'(s ? 16'(if2.Sum) : if4.Sum), exp_sum);
    chk("done_ovf", int'(s ? if2.ovf : if4.ovf), int'(exp_ovf));
  endtask
  // scoreboard: every consumed result must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && !clr4 && if4.out_valid && if4.out_ready) begin
      n_checks++;
      if (q4.size() == 0) begin
        n_err++;
        $display("FAIL sb4_unexpected: got sum %0d ovf %0d with nothing expected", if4.Sum, if4.ovf);
      end else begin
        e4 = q4.pop_front();
        if ({if4.ovf, if4.Sum} !== e4) begin
          n_err++;
          $display("FAIL sb4_result: got sum %0d ovf %0d expected sum %0d ovf %0d", if4.Sum, if4.ovf, e4[15:0], e4[16]);
        end
      end
    end
    if (!rst && !clr2 && if2.out_valid && if2.out_ready) begin
      n_checks++;
      if (q2.size() == 0) begin
        n_err++;
        $display("FAIL sb2_unexpected: got sum %0d ovf %0d with nothing expected", if2.Sum, if2.ovf);
      end else begin
        e2 = q2.pop_front();
        if ({if2.ovf, if2.Sum} !== e2) begin
          n_err++;
          $display("FAIL sb2_result: got sum %0d ovf %0d expected sum %0d ovf %0d", if2.Sum, if2.ovf, e2[7:0], e2[8]);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    if4.in_valid = 1'b0; if4.A = '0; if4.B = '0; if4.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.A = '0; if2.B = '0; if2.out_ready = 1'b1;
    repeat (2) step();
    chk("rst_in_ready", int'(if4.in_ready), 1);
    chk("rst_out_valid", int'(if4.out_valid), 0);
    chk("rst_sum", int'(if4.Sum), 0);
    chk("rst_ovf", int'(if4.ovf), 0);
    rst = 1'b0;
    step();
    av = '{4'd3, 4'd15, 4'd0, 4'd9};
    bv = '{4'd5, 4'd15, 4'd7, 4'd2};
    frame(0, 4, 0, 258, 1'b0);
    step();
    chk("reopen_in_ready", int'(if4.in_ready), 1);
    chk("reopen_sum", int'(if4.Sum), 0);
    if4.out_ready = 1'b0;
    frame(0, 4, 0, 258, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if4.in_valid = 1'b1; if4.A = 4'd7; if4.B = 4'd7;
      step();
      chk("bp_out_valid", int'(if4.out_valid), 1);
      chk("bp_in_ready", int'(if4.in_ready), 0);
      chk("bp_sum", int'(if4.Sum), 258);
    end
    if4.in_valid = 1'b0;
    if4.out_ready = 1'b1;
    step();
    chk("bp_next_sum", int'(if4.Sum), 0);
    chk("bp_next_in_ready", int'(if4.in_ready), 1);
    frame(0, 4, 3, 258, 1'b0);
    step();
    put(0, 4'd1, 4'd1);
    put(0, 4'd1, 4'd1);
    chk("pre_clr_sum", int'(if4.Sum), 1);
    clr4 = 1'b1; if4.in_valid = 1'b1; if4.A = 4'd9; if4.B = 4'd9;
    step();
    clr4 = 1'b0; if4.in_valid = 1'b0;
    chk("clr_sum", int'(if4.Sum), 0);
    chk("clr_in_ready", int'(if4.in_ready), 1);
    step();
    chk("clr_pending_dropped", int'(if4.Sum), 0);
    av = '{4'd2, 4'd2, 4'd2, 4'd2};
    bv = '{4'd2, 4'd2, 4'd2, 4'd2};
    frame(0, 4, 0, 16, 1'b0);
    step();
    put(0, 4'd2, 4'd3);
    put(0, 4'd2, 4'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_sum", int'(if4.Sum), 0);
    chk("mrst_ovf", int'(if4.ovf), 0);
    chk("mrst_out_valid", int'(if4.out_valid), 0);
    chk("mrst_in_ready", int'(if4.in_ready), 1);
    step();
    chk("mrst_pending_dropped", int'(if4.Sum), 0);
    frame(0, 4, 0, 16, 1'b0);
    step();
    av = '{4'd15, 4'd15, 4'd0, 4'd0};
    bv = '{4'd15, 4'd15, 4'd0, 4'd0};
    frame(1, 2, 0, 194, 1'b1);
    step();
    av = '{4'd1, 4'd1, 4'd0, 4'd0};
    bv = '{4'd1, 4'd1, 4'd0, 4'd0};
    frame(1, 2, 0, 2, 1'b0);
    step();
    for (int k = 0; k < 16; k++) begin
      av = '{4'(k), 4'd0, 4'd0, 4'd0};
      bv = '{4'd15, 4'd0, 4'd0, 4'd0};
      frame(1, 2, 0, 15 * k, 1'b0);
      step();
    end
    repeat (3) step();
    chk("q4_drained", q4.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
